// File: rtl/instr_encoder.sv
// instr_encoder: encodes mnemonic-level requests into 32-bit MIPS words, queues them
// in a DEPTH-entry FIFO and writes them to instruction memory at consecutive addresses.
// Latency: a request accepted at edge k raises im_we from edge k+1. Throughput is 1 word/cycle.
// Backpressure: req_ready = registered count < DEPTH. A write holds im_we/addr/wdata until im_ack.
//
// Ports:
//   clk, rstn                    clock and async active-low reset
//   req_valid/req_ready, req_*   request handshake and instruction fields
//   err_clr, err_illegal         sticky illegal-op flag and its clear
//   im_we/im_addr/im_wdata/im_ack  acknowledged write port into instruction memory
//   words_written, idle          status
module instr_encoder #(
  parameter int              DEPTH  = 4,
  parameter int              ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              err_clr,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic              err_illegal,
  output logic [15:0]       words_written,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic        op_legal;
  logic        is_r;
  logic        is_j;
  logic [5:0]  opc;
  logic [5:0]  funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_sh;
  logic [31:0] enc_word;

  always_comb begin
    op_legal = 1'b1;
    is_r     = 1'b0;
    is_j     = 1'b0;
    opc      = 6'h00;
    funct    = 6'h00;
    f_rs     = req_rs;
    f_rt     = req_rt;
    f_rd     = req_rd;
    f_sh     = 5'd0;   // shamt only survives for the three shift ops
    case (req_op)
      5'd0:  begin is_r = 1'b1; funct = 6'h21; end                       // ADDU
      5'd1:  begin is_r = 1'b1; funct = 6'h23; end                       // SUBU
      5'd2:  begin is_r = 1'b1; funct = 6'h20; end                       // ADD
      5'd3:  begin is_r = 1'b1; funct = 6'h22; end                       // SUB
      5'd4:  begin is_r = 1'b1; funct = 6'h2A; end                       // SLT
      5'd5:  begin is_r = 1'b1; funct = 6'h00; f_rs = '0; f_sh = req_shamt; end // SLL
      5'd6:  begin is_r = 1'b1; funct = 6'h02; f_rs = '0; f_sh = req_shamt; end // SRL
      5'd7:  begin is_r = 1'b1; funct = 6'h03; f_rs = '0; f_sh = req_shamt; end // SRA
      5'd8:  begin is_r = 1'b1; funct = 6'h08; f_rt = '0; f_rd = '0; end // JR
      5'd19: begin is_r = 1'b1; funct = 6'h25; end                       // OR
      5'd20: begin is_r = 1'b1; funct = 6'h24; end                       // AND
      5'd9:  opc = 6'h08;                                                // ADDI
      5'd10: opc = 6'h0D;                                                // ORI
      5'd11: begin opc = 6'h0F; f_rs = '0; end                           // LUI
      5'd12: opc = 6'h04;                                                // BEQ
      5'd13: opc = 6'h05;                                                // BNE
      5'd14: opc = 6'h23;                                                // LW
      5'd15: opc = 6'h2B;                                                // SW
      5'd18: opc = 6'h0A;                                                // SLTI
      5'd16: begin is_j = 1'b1; opc = 6'h02; end                         // J
      5'd17: begin is_j = 1'b1; opc = 6'h03; end                         // JAL
      default: op_legal = 1'b0;
    endcase

    if (is_j) begin
      enc_word = {opc, req_target};
    end else if (is_r) begin
      enc_word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    end else begin
      enc_word = {opc, f_rs, f_rt, req_imm};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  state_t           state_q;
  logic             im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]      im_wdata_q;
  logic [15:0]      words_q;
  logic             err_q;

  logic accept;
  logic push;
  logic pop;
  logic fifo_ne;

  // Ready is derived from the registered count only, so a full FIFO never
  // accepts even on a cycle where the write stage pops.
  assign req_ready = (cnt_q != FULL);
  assign accept    = req_valid & req_ready;
  assign push      = accept & op_legal;
  assign fifo_ne   = (cnt_q != '0);
  // IDLE pops whenever data is waiting; WRITE pops only on the ack edge.
  assign pop       = fifo_ne & ((state_q == S_IDLE) | im_ack);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  // ---------------------------------------------------------------------------
  // Write stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE;
      im_wdata_q <= '0;
      words_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fifo_ne) begin
            im_wdata_q <= mem_q[rd_ptr_q];
            im_we_q    <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (im_ack) begin
            im_addr_q <= im_addr_q + ADDR_W'(4);
            words_q   <= words_q + 16'd1;
            if (fifo_ne) begin
              im_wdata_q <= mem_q[rd_ptr_q];
            end else begin
              im_we_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          im_we_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (accept && !op_legal) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign im_we         = im_we_q;
  assign im_addr       = im_addr_q;
  assign im_wdata      = im_wdata_q;
  assign words_written = words_q;
  assign err_illegal   = err_q;
  assign idle          = (cnt_q == '0) & ~im_we_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: scoreboard of expected memory writes, filled as requests
// are accepted and drained by a monitor on every acknowledged write. A second instance
// with BASE=0xFFC shares all inputs and must mirror the first at an offset address.
module tb_instr_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op, req_rs, req_rt, req_rd, req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        err_clr;
  logic        im_we;
  logic [11:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_ack;
  logic        err_illegal;
  logic [15:0] words_written;
  logic        idle;

  logic        req_ready2, im_we2, err_illegal2, idle2;
  logic [11:0] im_addr2;
  logic [31:0] im_wdata2;
  logic [15:0] words_written2;

  instr_encoder #(.DEPTH(4), .ADDR_W(12), .BASE(12'h000)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .err_clr(err_clr), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .im_ack(im_ack), .err_illegal(err_illegal), .words_written(words_written),
    .idle(idle)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(12), .BASE(12'hFFC)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .err_clr(err_clr), .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2),
    .im_ack(im_ack), .err_illegal(err_illegal2), .words_written(words_written2),
    .idle(idle2)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [11:0] model_addr;
  int          exp_words;
  bit          saw_illegal;
  bit          rand_ack = 1'b0;

  // Reference tables: 0 = illegal, 1 = R-type (code = funct), 2 = I-type, 3 = J-type (code = opcode)
  int kind [32];
  int code [32];

  function automatic void init_tables();
    for (int i = 0; i < 32; i++) begin kind[i] = 0; code[i] = 0; end
    kind[0]=1;  code[0]=8'h21;  kind[1]=1;  code[1]=8'h23;  kind[2]=1;  code[2]=8'h20;
    kind[3]=1;  code[3]=8'h22;  kind[4]=1;  code[4]=8'h2A;  kind[5]=1;  code[5]=8'h00;
    kind[6]=1;  code[6]=8'h02;  kind[7]=1;  code[7]=8'h03;  kind[8]=1;  code[8]=8'h08;
    kind[19]=1; code[19]=8'h25; kind[20]=1; code[20]=8'h24;
    kind[9]=2;  code[9]=8'h08;  kind[10]=2; code[10]=8'h0D; kind[11]=2; code[11]=8'h0F;
    kind[12]=2; code[12]=8'h04; kind[13]=2; code[13]=8'h05; kind[14]=2; code[14]=8'h23;
    kind[15]=2; code[15]=8'h2B; kind[18]=2; code[18]=8'h0A;
    kind[16]=3; code[16]=8'h02; kind[17]=3; code[17]=8'h03;
  endfunction

  function automatic logic [31:0] ref_enc(int op, int rs, int rt, int rd, int sh, int imm, int tgt);
    longint w;
    bit shift_op = (op >= 5 && op <= 7);
    w = 0;
    if (kind[op] == 1) begin
      if (shift_op) rs = 0; else sh = 0;
      if (op == 8) begin rt = 0; rd = 0; end
      w = rs * (2**21) + rt * (2**16) + rd * (2**11) + sh * (2**6) + code[op];
    end else if (kind[op] == 2) begin
      if (op == 11) rs = 0;
      w = longint'(code[op]) * (2**26) + rs * (2**21) + rt * (2**16) + imm;
    end else if (kind[op] == 3) begin
      w = longint'(code[op]) * (2**26) + tgt;
    end
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every acknowledged write must match the head of the scoreboard.
  exp_t        mon_e;
  logic [11:0] mon_a2;
  always @(negedge clk) begin
    if (rstn === 1'b1 && im_we === 1'b1 && im_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, required no write at %0t", im_addr, im_wdata, $time);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_a2 = mon_e.addr + 12'hFFC;
        chk("wr_addr", {20'h0, im_addr}, {20'h0, mon_e.addr});
        chk("wr_data", im_wdata, mon_e.data);
        chk("wr_addr_base_ffc", {20'h0, im_addr2}, {20'h0, mon_a2});
        chk("wr_data_base_ffc", im_wdata2, mon_e.data);
      end
    end
  end

  // Random ack generator, only active during the randomized phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ack) im_ack = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_req(input int op, input int rs, input int rt, input int rd,
                           input int sh, input int imm, input int tgt);
    req_valid  = 1'b1;
    req_op     = op[4:0];
    req_rs     = rs[4:0];
    req_rt     = rt[4:0];
    req_rd     = rd[4:0];
    req_shamt  = sh[4:0];
    req_imm    = imm[15:0];
    req_target = tgt[25:0];
  endtask

  // Issue one request and wait (bounded) for it to be accepted.
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tgt,
                      input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
    bit acc;
    int n;
    exp_t e;
    drive_req(op, rs, rt, rd, sh, imm, tgt);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
    end else if (kind[op] != 0) begin
      e.addr = model_addr;
      e.data = use_k ? k : ref_enc(op, rs, rt, rd, sh, imm, tgt);
      sb_q.push_back(e);
      model_addr = model_addr + 12'd4;
      exp_words++;
    end else begin
      saw_illegal = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (idle !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: idle still %b after 500 cycles, required 1", name, idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    err_clr = 1'b0;
    im_ack = 1'b0;
    sb_q.delete();
    model_addr  = 12'h000;
    exp_words   = 0;
    saw_illegal = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    init_tables();
    do_reset();

    // Reset state
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_words", words_written, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_addr_base_ffc", im_addr2, 12'hFFC);

    // ADDU then ORI, ack tied high, back-to-back
    im_ack = 1'b1;
    send(0, 1, 2, 3, 0, 0, 0, 1'b1, 32'h00221821);
    send(10, 0, 8, 0, 0, 16'h1234, 0, 1'b1, 32'h34081234);
    @(negedge clk);
    chk("b2b_first_we", im_we, 1);
    chk("b2b_first_data", im_wdata, 32'h00221821);
    @(negedge clk);
    chk("b2b_second_we", im_we, 1);
    chk("b2b_second_data", im_wdata, 32'h34081234);
    @(posedge clk);
    #1;
    wait_idle("idle_after_pair");
    chk("pair_words", words_written, 2);
    chk("pair_idle", idle, 1);

    // Accept-to-write latency, plus the fixed encodings
    send(5, 7, 5, 4, 2, 0, 0, 1'b1, 32'h00052080);
    @(negedge clk);
    chk("lat_edge_k", im_we, 0);
    @(negedge clk);
    chk("lat_edge_k1", im_we, 1);
    @(posedge clk);
    #1;
    send(14, 29, 9, 0, 0, 16'hFFFC, 0, 1'b1, 32'h8FA9FFFC);
    send(16, 0, 0, 0, 0, 0, 26'h0100000, 1'b1, 32'h08100000);
    send(17, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF);
    wait_idle("idle_after_fixed");

    // Backpressure: ack held low, five requests fill write stage + FIFO
    im_ack = 1'b0;
    for (int i = 0; i < 5; i++) send(1, i, i + 1, i + 2, 0, 0, 0);
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    chk("full_we", im_we, 1);
    drive_req(2, 9, 9, 9, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("sixth_waits", req_ready, 0);
    end
    @(posedge clk);
    #1;
    im_ack = 1'b1;
    send(2, 9, 9, 9, 0, 0, 0);
    wait_idle("idle_after_full");
    chk("full_words", words_written, exp_words);

    // Illegal op between two ADDUs
    do_reset();
    im_ack = 1'b1;
    send(0, 4, 5, 6, 0, 0, 0);
    send(25, 1, 1, 1, 1, 1, 1);
    send(0, 7, 8, 9, 0, 0, 0);
    wait_idle("idle_after_illegal");
    chk("illegal_err", err_illegal, 1);
    chk("illegal_words", words_written, 2);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err_illegal, 0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    send(26, 0, 0, 0, 0, 0, 0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_wins", err_illegal, 1);
    @(posedge clk);
    #1;

    // Randomized traffic with random acks
    do_reset();
    rand_ack = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int op;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 20));
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 16'hFFFF), $urandom_range(0, 26'h3FFFFFF));
    end
    rand_ack = 1'b0;
    @(posedge clk);
    #2;
    im_ack = 1'b1;
    wait_idle("idle_after_random");
    chk("rand_words", words_written, exp_words);
    chk("rand_err", err_illegal, saw_illegal);

    // Reset in the middle of a write with words queued
    im_ack = 1'b0;
    send(0, 1, 1, 1, 0, 0, 0);
    send(0, 2, 2, 2, 0, 0, 0);
    send(0, 3, 3, 3, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_we", im_we, 1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("reset_we_drop", im_we, 0);
    chk("reset_we_drop_base_ffc", im_we2, 0);
    sb_q.delete();
    model_addr = 12'h000;
    exp_words  = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_addr", im_addr, 0);
    chk("post_reset_idle", idle, 1);
    chk("post_reset_words", words_written, 0);
    @(posedge clk);
    #1;
    im_ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(0, 10, 11, 12, 0, 0, 0);
    wait_idle("idle_after_reset");
    chk("post_reset_written", words_written, 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
